hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Sequences the 5-stage pipeline around hazards that the forwarding network cannot resolve.
- Detects load-use hazards and hazards on branch operands compared in ID.
- Drives PC/IF-ID write-enables, the ID/EX bubble and the IF/ID flush.
- Owns the busy/scheduling state of the multi-cycle HI/LO multiply/divide unit, and blocks ID until that unit is free.

Parameters:
- MULT_LAT, 4, multiply latency in cycles (≥1).
- DIV_LAT, 32, divide latency in cycles (≥1).
- CNT_W, 6, latency counter width; must hold max(MULT_LAT, DIV_LAT)-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ID_rs  in  5  rs of the instruction in ID.
- ID_rt  in  5  rt of the instruction in ID.
- ID_UseRt  in  1  ID instruction reads rt.
- ID_Branch  in  1  ID instruction is a branch compared in ID.
- BranchTaken  in  1  branch/jump in ID resolves taken.
- ID_MdStart  in  1  ID instruction is mult/div.
- ID_MdOp  in  1  0 = mult, 1 = div.
- ID_MdRead  in  1  ID instruction is mfhi, mflo, mthi or mtlo.
- EX_RegWr  in  1  EX instruction writes the register file.
- EX_MemRead  in  1  EX instruction is a load.
- EX_write_reg  in  5  destination register of the EX instruction.
- MEM_MemRead  in  1  MEM instruction is a load.
- MEM_write_reg  in  5  destination register of the MEM instruction.
- PC_Write  out  1  PC write enable.
- IF_ID_Write  out  1  IF/ID register write enable.
- ID_EX_Flush  out  1  insert a bubble into ID/EX.
- IF_ID_Flush  out  1  squash the instruction in IF/ID.
- MdAccept  out  1  mult/div issued this cycle.
- MdBusy  out  1  mult/div unit occupied.
- MdDone  out  1  one-cycle pulse when HI/LO are valid.
- StallCycles  out  16  stall-cycle counter (see Optional Feature).

Behaviour:
- Register 0 never matches. A match on rt counts only when ID_UseRt=1 or ID_Branch=1.
- Stall terms, combinational:
  - load_use = EX_MemRead & EX_write_reg matches rs/rt.
  - br_ex = ID_Branch & EX_RegWr & EX_write_reg matches rs/rt.
  - br_mem = ID_Branch & MEM_MemRead & MEM_write_reg matches rs/rt.
  - md_conf = (state==BUSY) & (ID_MdStart | ID_MdRead).
- stall = OR of all four terms.
- While stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0. Stall always wins over BranchTaken, because branch operands are stale.
- While stall=0: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=BranchTaken.
- FSM states: IDLE and BUSY. The state and the counter cnt are registered.
- IDLE:
  - If ID_MdStart & ~stall: MdAccept=1 (combinational).
  - On that edge: cnt ← (ID_MdOp ? DIV_LAT : MULT_LAT) − 1, state ← BUSY.
- BUSY:
  - MdBusy=1 (decoded from state).
  - If cnt==0: state ← IDLE and MdDone ← 1. Otherwise cnt ← cnt − 1.
  - MdBusy is therefore high for exactly LAT cycles after the accept edge.
- MdDone is registered. It is high only in the first IDLE cycle after BUSY, and cleared on the next edge.
- Back-to-back mult/div:
  - A start arriving during BUSY stalls.
  - It is accepted in the cycle where MdDone=1, provided no other stall term is active.
  - An ID_MdRead in that same cycle is not stalled.
- Every stall term is evaluated each cycle. There is no latched stall history, so load_use lasts exactly 1 cycle.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, cnt=0, MdDone=0, StallCycles=0.
  - Outputs while inputs are idle: PC_Write=1, IF_ID_Write=1, ID_EX_Flush=0, IF_ID_Flush=0, MdAccept=0, MdBusy=0.
  - Reset during BUSY aborts the operation with no MdDone pulse.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined: StallCycles increments on each clock edge where stall=1, saturating at 16'hFFFF. It is cleared only by reset.
- When undefined: StallCycles is tied to 16'h0000 and no counter logic is built.

Test Plan:
- Load-use on rs: EX_MemRead=1, EX_write_reg=8, ID_rs=8 → exactly 1 cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. Repeat with EX_write_reg=0 → no stall.
- Branch after ALU op: ID_Branch=1, ID_rt=9, EX_RegWr=1, EX_write_reg=9, BranchTaken=1 → stall with IF_ID_Flush=0. On the next cycle, with EX cleared → IF_ID_Flush=1.
- Mult issue then mfhi:
  - ID_MdStart=1, ID_MdOp=0 → MdAccept=1.
  - MdBusy=1 for 4 cycles.
  - mfhi presented during BUSY stalls all 4 cycles.
  - MdDone=1 in the following cycle, and mfhi passes in that cycle.
- Div followed immediately by mult:
  - Div: MdBusy=1 for 32 cycles.
  - Mult is stalled throughout.
  - MdAccept for the mult occurs in the MdDone cycle, then MdBusy=1 for 4 more cycles.
- Reset mid-div: drop rst_n at BUSY cycle 10 → MdBusy=0 immediately. MdDone is never asserted, and a new div is accepted after release.
- HAZARD_PERF_EN defined: 3 load-use stalls plus one 4-cycle mult conflict → StallCycles=7. With the macro undefined → StallCycles=0.

Source files
------------

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side signal bundle for hazard_stall_controller: ID/EX/MEM hazard inputs and
// the stall/flush/mult-div control outputs.
`timescale 1ns/1ps
interface hazard_stall_controller_if;
  logic [4:0]  ID_rs;
  logic [4:0]  ID_rt;
  logic        ID_UseRt;
  logic        ID_Branch;
  logic        BranchTaken;
  logic        ID_MdStart;
  logic        ID_MdOp;
  logic        ID_MdRead;
  logic        EX_RegWr;
  logic        EX_MemRead;
  logic [4:0]  EX_write_reg;
  logic        MEM_MemRead;
  logic [4:0]  MEM_write_reg;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        ID_EX_Flush;
  logic        IF_ID_Flush;
  logic        MdAccept;
  logic        MdBusy;
  logic        MdDone;
  logic [15:0] StallCycles;

  // Pipeline side drives the hazard inputs and consumes the controls.
  modport master (
    output ID_rs, ID_rt, ID_UseRt, ID_Branch, BranchTaken, ID_MdStart, ID_MdOp, ID_MdRead,
           EX_RegWr, EX_MemRead, EX_write_reg, MEM_MemRead, MEM_write_reg,
    input  PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, MdAccept, MdBusy, MdDone,
           StallCycles
  );

  modport slave (
    input  ID_rs, ID_rt, ID_UseRt, ID_Branch, BranchTaken, ID_MdStart, ID_MdOp, ID_MdRead,
           EX_RegWr, EX_MemRead, EX_write_reg, MEM_MemRead, MEM_write_reg,
    output PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush, MdAccept, MdBusy, MdDone,
           StallCycles
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / ID-branch hazard stall control plus HI/LO mult/div busy scheduling.
// Optional stall-cycle counter built only when HAZARD_PERF_EN is defined.
`timescale 1ns/1ps
module hazard_stall_controller #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32,
  parameter int unsigned CNT_W    = 6
) (
  input logic                      clk,
  input logic                      rst_n,
  hazard_stall_controller_if.slave hz
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [CNT_W-1:0] MultInit = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DivInit  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  state_e           stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             mdDoneQ, mdDoneD;
  logic             mdAccept;

  logic rtLive, exHit, memHit;
  logic loadUse, brEx, brMem, mdConf, stall, busy;

  // $zero never matches; rt only matters when the ID instruction actually reads it.
  function automatic logic regHit(input logic [4:0] wr, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic rtUsed);
    return (wr != 5'd0) && ((wr == rs) || (rtUsed && (wr == rt)));
  endfunction

  assign rtLive  = hz.ID_UseRt | hz.ID_Branch;
  assign exHit   = regHit(hz.EX_write_reg, hz.ID_rs, hz.ID_rt, rtLive);
  assign memHit  = regHit(hz.MEM_write_reg, hz.ID_rs, hz.ID_rt, rtLive);
  assign busy    = (stateQ == StBusy);

  assign loadUse = hz.EX_MemRead & exHit;
  assign brEx    = hz.ID_Branch & hz.EX_RegWr & exHit;
  assign brMem   = hz.ID_Branch & hz.MEM_MemRead & memHit;
  assign mdConf  = busy & (hz.ID_MdStart | hz.ID_MdRead);
  assign stall   = loadUse | brEx | brMem | mdConf;

  // Stall overrides a taken branch: its operands were stale this cycle.
  always_comb begin
    hz.PC_Write    = ~stall;
    hz.IF_ID_Write = ~stall;
    hz.ID_EX_Flush = stall;
    hz.IF_ID_Flush = ~stall & hz.BranchTaken;
    hz.MdAccept    = mdAccept;
    hz.MdBusy      = busy;
    hz.MdDone      = mdDoneQ;
  end

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    mdDoneD  = 1'b0;
    mdAccept = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (hz.ID_MdStart && !stall) begin
          mdAccept = 1'b1;
          stateD   = StBusy;
          cntD     = hz.ID_MdOp ? DivInit : MultInit;
        end
      end
      StBusy: begin
        if (cntQ == '0) begin
          stateD  = StIdle;
          mdDoneD = 1'b1;
        end else begin
          cntD = cntQ - CntOne;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= StIdle;
      cntQ    <= '0;
      mdDoneQ <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      mdDoneQ <= mdDoneD;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stallCntQ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCntQ <= 16'h0000;
    end else if (stall && (stallCntQ != 16'hFFFF)) begin
      stallCntQ <= stallCntQ + 16'd1;
    end
  end

  assign hz.StallCycles = stallCntQ;
`else
  assign hz.StallCycles = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed scoreboard bench for hazard_stall_controller.
`timescale 1ns/1ps
module tb_hazard_stall_controller;

  localparam int MultLat = 4;
  localparam int DivLat  = 32;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       useRt;
    logic       branch;
    logic       taken;
    logic       mdStart;
    logic       mdOp;
    logic       mdRead;
    logic       exRegWr;
    logic       exMemRead;
    logic [4:0] exWr;
    logic       memMemRead;
    logic [4:0] memWr;
  } stim_t;

  typedef struct packed {
    logic        pcWrite;
    logic        ifIdWrite;
    logic        idExFlush;
    logic        ifIdFlush;
    logic        mdAccept;
    logic        mdBusy;
    logic        mdDone;
    logic [15:0] stallCycles;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_stall_controller_if hif ();

  hazard_stall_controller #(
    .MULT_LAT (MultLat),
    .DIV_LAT  (DivLat),
    .CNT_W    (6)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hif.slave)
  );

  resp_t expQ[$];
  int    checks = 0;
  int    errors = 0;

  // Reference model: remaining busy cycles, pending done pulse, stall count.
  int mdLeft   = 0;
  bit doneNow  = 1'b0;
  int perfCnt  = 0;

  function automatic bit hits(input logic [4:0] w, input stim_t s);
    return (w != 0) && ((w == s.rs) || ((w == s.rt) && (s.useRt || s.branch)));
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  task automatic doCycle(input stim_t s, input bit rstVal);
    resp_t e;
    bit    busy, stall, acc;
    @(negedge clk);
    rst_n             = rstVal;
    hif.ID_rs         = s.rs;
    hif.ID_rt         = s.rt;
    hif.ID_UseRt      = s.useRt;
    hif.ID_Branch     = s.branch;
    hif.BranchTaken   = s.taken;
    hif.ID_MdStart    = s.mdStart;
    hif.ID_MdOp       = s.mdOp;
    hif.ID_MdRead     = s.mdRead;
    hif.EX_RegWr      = s.exRegWr;
    hif.EX_MemRead    = s.exMemRead;
    hif.EX_write_reg  = s.exWr;
    hif.MEM_MemRead   = s.memMemRead;
    hif.MEM_write_reg = s.memWr;
    if (!rstVal) begin
      mdLeft  = 0;
      doneNow = 1'b0;
      perfCnt = 0;
    end
    busy  = (mdLeft > 0);
    stall = (s.exMemRead && hits(s.exWr, s)) ||
            (s.branch && s.exRegWr && hits(s.exWr, s)) ||
            (s.branch && s.memMemRead && hits(s.memWr, s)) ||
            (busy && (s.mdStart || s.mdRead));
    acc   = !busy && s.mdStart && !stall;
    e.pcWrite   = !stall;
    e.ifIdWrite = !stall;
    e.idExFlush = stall;
    e.ifIdFlush = !stall && s.taken;
    e.mdAccept  = acc;
    e.mdBusy    = busy;
    e.mdDone    = doneNow;
`ifdef HAZARD_PERF_EN
    e.stallCycles = 16'(perfCnt);
`else
    e.stallCycles = 16'h0000;
`endif
    expQ.push_back(e);
    if (rstVal) begin
      if (stall && perfCnt < 65535) perfCnt++;
      if (busy) begin
        mdLeft--;
        doneNow = (mdLeft == 0);
      end else begin
        doneNow = 1'b0;
        if (acc) mdLeft = s.mdOp ? DivLat : MultLat;
      end
    end
  endtask

  // Monitor: outputs are presented every cycle; sample mid-low-phase.
  initial begin
    resp_t e, g;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        g = {hif.PC_Write, hif.IF_ID_Write, hif.ID_EX_Flush, hif.IF_ID_Flush,
             hif.MdAccept, hif.MdBusy, hif.MdDone, hif.StallCycles};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL cycle t=%0t got pcw=%b ifw=%b exfl=%b iffl=%b acc=%b busy=%b done=%b sc=%0d required pcw=%b ifw=%b exfl=%b iffl=%b acc=%b busy=%b done=%b sc=%0d",
                   $time, g.pcWrite, g.ifIdWrite, g.idExFlush, g.ifIdFlush, g.mdAccept,
                   g.mdBusy, g.mdDone, g.stallCycles, e.pcWrite, e.ifIdWrite, e.idExFlush,
                   e.ifIdFlush, e.mdAccept, e.mdBusy, e.mdDone, e.stallCycles);
        end
      end
    end
  end

  task automatic checkVal(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    stim_t s;
    int    busyCnt;
    hif.ID_rs = '0; hif.ID_rt = '0; hif.ID_UseRt = 0; hif.ID_Branch = 0;
    hif.BranchTaken = 0; hif.ID_MdStart = 0; hif.ID_MdOp = 0; hif.ID_MdRead = 0;
    hif.EX_RegWr = 0; hif.EX_MemRead = 0; hif.EX_write_reg = '0;
    hif.MEM_MemRead = 0; hif.MEM_write_reg = '0;

    repeat (2) doCycle(idle(), 1'b0);
    doCycle(idle(), 1'b1);

    // Three load-use stalls, then a 4-cycle mult conflict: 7 stall cycles.
    for (int i = 0; i < 3; i++) begin
      s = idle(); s.exMemRead = 1; s.exWr = 5'd8; s.rs = 5'd8;
      doCycle(s, 1'b1);
      doCycle(idle(), 1'b1);
    end
    s = idle(); s.exMemRead = 1; s.exWr = 5'd0; s.rs = 5'd0;
    doCycle(s, 1'b1);
    s = idle(); s.mdStart = 1; s.mdOp = 0;
    doCycle(s, 1'b1);
    s = idle(); s.mdRead = 1;
    repeat (MultLat) doCycle(s, 1'b1);
    doCycle(s, 1'b1);  // done cycle: mfhi passes
    doCycle(idle(), 1'b1);
    #2;
`ifdef HAZARD_PERF_EN
    checkVal("perf_stall_cycles", int'(hif.StallCycles), 7);
`else
    checkVal("perf_stall_cycles", int'(hif.StallCycles), 0);
`endif

    // Branch on rt after ALU op: stall, then taken flush once EX clears.
    s = idle(); s.branch = 1; s.rt = 5'd9; s.exRegWr = 1; s.exWr = 5'd9; s.taken = 1;
    doCycle(s, 1'b1);
    #2 checkVal("branch_stall_no_flush", int'(hif.IF_ID_Flush), 0);
    s.exRegWr = 0; s.exWr = 5'd0;
    doCycle(s, 1'b1);
    #2 checkVal("branch_flush", int'(hif.IF_ID_Flush), 1);

    // Div then mult back-to-back.
    s = idle(); s.mdStart = 1; s.mdOp = 1;
    doCycle(s, 1'b1);
    s.mdOp = 0;
    busyCnt = 0;
    for (int i = 0; i < DivLat; i++) begin
      doCycle(s, 1'b1);
      #2 if (hif.MdBusy) busyCnt++;
    end
    checkVal("div_busy_cycles", busyCnt, DivLat);
    doCycle(s, 1'b1);
    #2 checkVal("mult_accept_in_done", int'(hif.MdAccept & hif.MdDone), 1);
    repeat (MultLat + 2) doCycle(idle(), 1'b1);

    // Reset mid-div aborts without a done pulse; a new div is then accepted.
    s = idle(); s.mdStart = 1; s.mdOp = 1;
    doCycle(s, 1'b1);
    repeat (10) doCycle(idle(), 1'b1);
    doCycle(idle(), 1'b0);
    #2 checkVal("reset_busy", int'(hif.MdBusy), 0);
    doCycle(idle(), 1'b1);
    doCycle(s, 1'b1);
    #2 checkVal("div_after_reset", int'(hif.MdAccept), 1);
    repeat (DivLat + 2) doCycle(idle(), 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      s.rs         = 5'($urandom_range(0, 3));
      s.rt         = 5'($urandom_range(0, 3));
      s.useRt      = 1'($urandom_range(0, 1));
      s.branch     = ($urandom_range(0, 3) == 0);
      s.taken      = 1'($urandom_range(0, 1));
      s.mdStart    = ($urandom_range(0, 7) == 0);
      s.mdOp       = ($urandom_range(0, 3) == 0);
      s.mdRead     = ($urandom_range(0, 7) == 0);
      s.exRegWr    = 1'($urandom_range(0, 1));
      s.exMemRead  = ($urandom_range(0, 3) == 0);
      s.exWr       = 5'($urandom_range(0, 3));
      s.memMemRead = ($urandom_range(0, 3) == 0);
      s.memWr      = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) doCycle(idle(), 1'b0);
      else doCycle(s, 1'b1);
    end

    repeat (2) doCycle(idle(), 1'b1);
    @(negedge clk);
    #4;
    checkVal("scoreboard_drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
